approx_add_pipe: RTL and testbench
==================================

// Module: approx_add_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined signed approximate adder for the wearable edge datapath.
//  Lower APX_BITS bits use a lower-part-OR scheme; upper bits are exact.
//  Approximation is switchable per transaction. Valid/ready handshakes on both sides.
//  Drop-in sequential successor to the fixed 16-bit combinational approximate adders.
// PARAMETERS
//  WIDTH     16  operand width, signed two's complement; range 4..64
//  APX_BITS  7   approximated LSBs; 0 = always exact; must be < WIDTH/2
//  SPLIT     WIDTH/2  bit index where stage 1 hands the carry to stage 2
// PORTS
//  clk        in   1        clock; all state updates on the rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        input beat valid
//  in_ready   out  1        block accepts the beat this cycle
//  in_a       in   WIDTH    operand A, signed
//  in_b       in   WIDTH    operand B, signed
//  in_apx     in   1        1 = approximate add, 0 = exact add; sampled with the beat
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts the result
//  out_sum    out  WIDTH+1  signed sum, sign-extended
//  err_clr    in   1        clears the error monitor (feature only)
//  err_max    out  WIDTH+1  running max |approx-exact| (feature only)
//  err_cnt    out  32       beats with nonzero error, saturates at 2^32-1 (feature only)
// BEHAVIOUR
//  Reset: stage valids, out_valid, out_sum, err_max and err_cnt = 0. in_ready = 1 during and after reset.
//  Arithmetic when apx=1 and APX_BITS>0:
//   - sum[i] = a[i]|b[i] for i<APX_BITS
//   - carry into bit APX_BITS = a[APX_BITS-1]&b[APX_BITS-1]
//   - bits APX_BITS..WIDTH-1 are exact; bit WIDTH = sign-correct carry-out (signed extension)
//  Arithmetic when apx=0: exact signed WIDTH+1 sum.
//  Stage 1 registers sum[SPLIT-1:0], the SPLIT carry, the upper operand slices and apx.
//  Stage 2 registers the upper bits into out_sum.
//  Latency: exactly 2 cycles from an accepted input to out_valid when no stall occurs.
//  Throughput: 1 beat/cycle.
//  Stall: adv = !out_valid | out_ready, applied globally; in_ready = adv.
//   - When adv=0, every stage register holds.
//   - out_sum and out_valid stay stable until the result is taken.
//  Bubbles: an empty stage is overwritten on adv. in_valid=0 inserts a bubble and never a stale result.
//  Simultaneous in_valid&in_ready and out_valid&out_ready: both transfers happen in the same cycle.
//  Reset mid-operation: all in-flight beats are dropped, with no partial output.
//  Overflow: impossible, because out_sum has WIDTH+1 bits and no wrap occurs.
// CONFIGURATION
//  Macro APPROX_ADD_ERR_MON_EN.
//  Defined:
//   - a parallel exact adder tracks each beat
//   - on each out_valid&out_ready: err_max <= max(err_max, |approx-exact|); err_cnt++ when nonzero
//   - err_clr zeroes both; if err_clr coincides with an output beat, the clear wins
//  Undefined: the ports exist but err_max and err_cnt are tied to 0 and err_clr is ignored. No monitor logic.
// STRUCTURE
//  Package approx_add_pkg:
//   - localparam DEF_WIDTH, DEF_APX_BITS
//   - typedef apx_mode_e {APX_EXACT, APX_LOA}
//   - function loa_add(a, b, apx_bits, cin) returning {cout, sum}
//   - function abs_diff
//  Sub-module approx_add_seg (one pipeline segment: an LO-OR/exact slice with carry in/out), instantiated twice.
//  Parameter checks in an initial block: APX_BITS<SPLIT, WIDTH>=4.
// TESTING  (WIDTH=16, APX_BITS=7)
//  1. A=0x007F, B=0x0001, apx=1 -> out_sum=0x0007F after 2 cycles. apx=0 -> 0x00080.
//  2. A=0x0040, B=0x0040, apx=1 -> 0x000C0. With the monitor: err_max=0x40, err_cnt=1.
//  3. A=0x8000, B=0x8000, apx=0 -> 0x10000 (-65536). A=0x7FFF, B=0x0001 -> 0x08000.
//  4. Stream 8 beats with out_ready low for cycles 3-5:
//      -> in_ready low for 3 cycles, out_sum held stable
//      -> all 8 results emerge in order, none lost or duplicated
//  5. Assert rst_n low with 2 beats in flight -> out_valid=0 immediately; no result for those beats after release.
//  6. err_clr on the same cycle as an erroneous output beat -> err_max=0, err_cnt=0. Random 10k-beat exact mode vs model -> err_cnt=0.

Source files
------------

// File: rtl/approx_add_pkg.sv
// Shared types and arithmetic helpers for the pipelined lower-part-OR approximate adder.
package approx_add_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_APX_BITS = 7;

  typedef enum logic {
    APX_EXACT = 1'b0,
    APX_LOA   = 1'b1
  } apx_mode_e;

  // Bits below apx_bits are ORed and only the top ORed pair feeds the carry chain.
  function automatic logic [64:0] loa_add(input logic [63:0] a, input logic [63:0] b,
                                          input int apx_bits, input logic cin);
    logic [63:0] s;
    logic        c;
    s = '0;
    c = cin;
    for (int i = 0; i < 64; i++) begin
      if (i < apx_bits) begin
        s[i] = a[i] | b[i];
        c    = a[i] & b[i];
      end else begin
        s[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    return {c, s};
  endfunction

  function automatic logic [64:0] abs_diff(input logic signed [64:0] a, input logic signed [64:0] b);
    logic signed [64:0] d;
    d = a - b;
    return (d < 0) ? -d : d;
  endfunction

endpackage

// File: rtl/approx_add_pipe_seg.sv
// approx_add_seg: one pipeline segment, an N-bit adder whose low APX_BITS bits may be LO-OR approximated.
module approx_add_seg
  import approx_add_pkg::*;
#(
  parameter int N        = 8,
  parameter int APX_BITS = 0
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         apx,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [64:0] r;
  logic [64:0] unused_r;

  // Operands are zero-padded, so the segment carry-out lands on bit N.
  assign r        = loa_add(64'(a), 64'(b), apx ? APX_BITS : 0, cin);
  assign sum      = r[N-1:0];
  assign cout     = r[N];
  assign unused_r = r;

endmodule

// File: rtl/approx_add_pipe.sv
// approx_add_pipe: 2-stage signed approximate adder with valid/ready on both sides.
// Optional error monitor enabled by defining APPROX_ADD_ERR_MON_EN.
module approx_add_pipe
  import approx_add_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int APX_BITS = DEF_APX_BITS,
  parameter int SPLIT    = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_apx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  input  logic             err_clr,
  output logic [WIDTH:0]   err_max,
  output logic [31:0]      err_cnt
);

  localparam int HI = WIDTH - SPLIT;

  if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("approx_add_pipe: WIDTH must be in 4..64");
  end
  if (APX_BITS >= SPLIT) begin : g_bad_apx
    $error("approx_add_pipe: APX_BITS must be below SPLIT");
  end

  // Handshake: a beat moves on a rising edge when valid and ready are both high.
  // adv stalls the whole pipe only while an unaccepted result is waiting.
  logic            adv;
  logic            v1;
  logic [SPLIT-1:0] lo_sum, lo_q;
  logic            lo_cout, c_q;
  logic [HI-1:0]   a_hi_q, b_hi_q, hi_sum;
  logic            hi_cout;
  apx_mode_e       mode_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  approx_add_seg #(.N(SPLIT), .APX_BITS(APX_BITS)) u_seg_lo (
    .a(in_a[SPLIT-1:0]), .b(in_b[SPLIT-1:0]), .apx(in_apx), .cin(1'b0),
    .sum(lo_sum), .cout(lo_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      lo_q   <= '0;
      c_q    <= 1'b0;
      a_hi_q <= '0;
      b_hi_q <= '0;
      mode_q <= APX_EXACT;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        lo_q   <= lo_sum;
        c_q    <= lo_cout;
        a_hi_q <= in_a[WIDTH-1:SPLIT];
        b_hi_q <= in_b[WIDTH-1:SPLIT];
        mode_q <= in_apx ? APX_LOA : APX_EXACT;
      end
    end
  end

  // Upper slice is always exact; the approximation lives entirely below SPLIT.
  approx_add_seg #(.N(HI), .APX_BITS(0)) u_seg_hi (
    .a(a_hi_q), .b(b_hi_q), .apx(mode_q == APX_LOA), .cin(c_q),
    .sum(hi_sum), .cout(hi_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (adv) begin
      out_valid <= v1;
      if (v1) out_sum <= {a_hi_q[HI-1] ^ b_hi_q[HI-1] ^ hi_cout, hi_sum, lo_q};
    end
  end

`ifdef APPROX_ADD_ERR_MON_EN
  logic [WIDTH:0] ex1_q, ex2_q;
  logic [64:0]    err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex1_q <= '0;
      ex2_q <= '0;
    end else if (adv) begin
      if (in_valid) ex1_q <= {in_a[WIDTH-1], in_a} + {in_b[WIDTH-1], in_b};
      if (v1)       ex2_q <= ex1_q;
    end
  end

  assign err_d = abs_diff(65'($signed(out_sum)), 65'($signed(ex2_q)));

  // A clear in the same cycle as an output beat discards that beat's error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_max <= '0;
      err_cnt <= '0;
    end else if (err_clr) begin
      err_max <= '0;
      err_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (err_d > 65'(err_max)) err_max <= err_d[WIDTH:0];
      if (err_d != '0 && err_cnt != '1) err_cnt <= err_cnt + 32'd1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_max        = '0;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Self-checking bench for approx_add_pipe (WIDTH=16, APX_BITS=7): vector table, corner sequences, random scoreboard.
module tb_approx_add_pipe;
  localparam int W = 16;
  localparam int K = 7;
`ifdef APPROX_ADD_ERR_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_apx, out_valid, out_ready, err_clr;
  logic [W-1:0] in_a, in_b;
  logic [W:0]   out_sum, err_max;
  logic [31:0]  err_cnt;

  always #5 clk = ~clk;

  approx_add_pipe #(.WIDTH(W), .APX_BITS(K), .SPLIT(W/2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_apx(in_apx), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .err_clr(err_clr),
    .err_max(err_max), .err_cnt(err_cnt)
  );

  int total = 0;
  int bad   = 0;
  logic [W:0] exp_q[$];
  logic [W:0] err_q[$];
  logic [W:0] exp_max;
  int         exp_cnt;
  logic       held_pending;
  logic [W:0] held_sum;
  int         got;
  logic       acc_flag, rdy_flag;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         apx;
    logic [W:0]   sum;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: upper part is the exact sum of the arithmetically shifted operands plus the LO carry.
  function automatic longint model(input logic [W-1:0] a, input logic [W-1:0] b, input logic apx);
    longint sa, sb, lo, c;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!apx) return sa + sb;
    lo = longint'((a | b) & ((1 << K) - 1));
    c  = longint'(a[K-1] & b[K-1]);
    return (((sa >>> K) + (sb >>> K) + c) <<< K) | lo;
  endfunction

  task automatic push_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic apx);
    longint r, e, d;
    logic [63:0] rv, dv;
    r  = model(a, b, apx);
    e  = model(a, b, 1'b0);
    d  = (r > e) ? r - e : e - r;
    rv = r;
    dv = d;
    exp_q.push_back(rv[W:0]);
    err_q.push_back(dv[W:0]);
  endtask

  // One clock: inputs were set at posedge+1; record handshakes, advance, then check any stall hold.
  task automatic cycle();
    logic [W:0] e, d;
    #1;
    rdy_flag = in_ready;
    acc_flag = in_valid && in_ready;
    held_pending = out_valid && !out_ready;
    held_sum = out_sum;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("out_extra", out_valid, 0);
      else begin
        e = exp_q.pop_front();
        d = err_q.pop_front();
        chk("out_sum", out_sum, e);
        if (!err_clr) begin
          if (d > exp_max) exp_max = d;
          if (d != 0) exp_cnt++;
        end
      end
      got++;
    end
    if (err_clr) begin
      exp_max = '0;
      exp_cnt = 0;
    end
    if (acc_flag) push_beat(in_a, in_b, in_apx);
    @(posedge clk);
    #1;
    if (held_pending) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", out_sum, held_sum);
    end
  endtask

  task automatic chk_mon(input string name);
    chk({name, "_err_max"}, err_max, MON ? 64'(exp_max) : 64'd0);
    chk({name, "_err_cnt"}, err_cnt, MON ? 64'(exp_cnt) : 64'd0);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) cycle();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, sent, low;
    vecs[0] = '{16'h007F, 16'h0001, 1'b1, 17'h0007F};
    vecs[1] = '{16'h007F, 16'h0001, 1'b0, 17'h00080};
    vecs[2] = '{16'h0040, 16'h0040, 1'b1, 17'h000C0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 17'h08000};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    vecs[7] = '{16'h8000, 16'h8000, 1'b1, 17'h10000};
    vecs[8] = '{16'h7FFF, 16'h7FFF, 1'b1, 17'h0FFFF};
    vecs[9] = '{16'h1234, 16'h0F0F, 1'b0, 17'h02143};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_apx = 1'b0;
    out_ready = 1'b1; err_clr = 1'b0;
    exp_max = '0; exp_cnt = 0; got = 0; held_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_sum", out_sum, 0);
    chk_mon("rst");
    rst_n = 1'b1;

    // Vector table: exact 2-cycle latency and value.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b; in_apx = vecs[i].apx;
      cycle();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_lat1_valid", i), out_valid, 0);
      cycle();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_sum", i), out_sum, vecs[i].sum);
      cycle();
    end
    chk_mon("table");

    // Monitor: single erroneous beat, then a clear coinciding with an erroneous output.
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    in_valid = 1'b1; in_a = 16'h0040; in_b = 16'h0040; in_apx = 1'b1;
    cycle(); in_valid = 1'b0; cycle(); cycle();
    chk("mon_one_err_max", err_max, MON ? 64'h40 : 64'h0);
    chk("mon_one_err_cnt", err_cnt, MON ? 64'd1 : 64'd0);
    in_valid = 1'b1;
    cycle(); in_valid = 1'b0; cycle();
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("mon_clr_err_max", err_max, 0);
    chk("mon_clr_err_cnt", err_cnt, 0);

    // Stream 8 beats with out_ready low for stream cycles 3-5.
    got = 0; sent = 0; low = 0; c = 0;
    while (c < 60 && (sent < 8 || got < 8)) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 8);
      in_a = W'($urandom); in_b = W'($urandom); in_apx = 1'($urandom);
      cycle();
      if (acc_flag) sent++;
      if (!rdy_flag && sent < 8) low++;
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_got", got, 8);
    chk("stream_in_ready_low", low, 3);
    chk("stream_q_empty", exp_q.size(), 0);

    // Reset with two beats in flight.
    in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_apx = 1'b0;
    cycle();
    in_a = 16'h0303; cycle();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    exp_q.delete(); err_q.delete(); exp_max = '0; exp_cnt = 0; held_pending = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("post_rst_idle%0d", i), out_valid, 0);
      cycle();
    end
    chk_mon("post_rst");

    // Random mixed traffic with random back-pressure.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a = W'($urandom); in_b = W'($urandom); in_apx = 1'($urandom);
      cycle();
    end
    drain();
    chk_mon("random_mixed");

    // Random exact-only traffic after a clear: monitor must see no error.
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 7) != 0);
      in_a = W'($urandom); in_b = W'($urandom); in_apx = 1'b0;
      cycle();
    end
    drain();
    chk("exact_err_cnt", err_cnt, 0);
    chk("exact_err_max", err_max, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
